// File: rtl/mem_if_pkg.sv
// Shared types for the 128-bit block memory interface (cache miss engines and memory responders).
package mem_if_pkg;

   localparam int unsigned BLK_W   = 128;
   localparam int unsigned MADDR_W = 28;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2,
      GAP  = 2'd3
   } mem_state_e;

   // One latched block request
   typedef struct packed {
      logic               is_write;
      logic [MADDR_W-1:0] addr;
      logic [BLK_W-1:0]   wdata;
   } mem_req_t;

endpackage

// File: rtl/mem_proto_checker.sv
// Sticky detector for initiator-side protocol violations on the block memory interface.
module mem_proto_checker
   import mem_if_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  mem_state_e         state,
   input  mem_req_t           lat_req,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [MADDR_W-1:0] mem_addr,
   input  logic [BLK_W-1:0]   mem_wdata,
   output logic               proto_err
);

   logic req_c;
   logic viol_c;

   // Write data is only required to be stable when the latched op is a write
   always_comb begin
      req_c  = mem_read | mem_write;
      viol_c = 1'b0;
      case (state)
         IDLE: viol_c = mem_read & mem_write;
         BUSY: viol_c = ~req_c
                      | (mem_addr != lat_req.addr)
                      | (lat_req.is_write & (mem_wdata != lat_req.wdata));
         GAP:  viol_c = req_c;
         default: viol_c = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         proto_err <= 1'b0;
      end else if (viol_c) begin
         proto_err <= 1'b1;
      end
   end

endmodule

// File: rtl/slow_mem_responder.sv
// Fixed-latency memory-side responder serving one 128-bit block per handshake.
// Optional protocol checker built when MEM_PROTO_CHECK_EN is defined; otherwise proto_err is tied low.
module slow_mem_responder
   import mem_if_pkg::*;
#(
   parameter int unsigned LATENCY = 4,
   parameter int unsigned IDX_W   = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [MADDR_W-1:0] mem_addr,
   input  logic [BLK_W-1:0]   mem_wdata,
   output logic [BLK_W-1:0]   mem_rdata,
   output logic               mem_ready,
   output logic               proto_err
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned DEPTH = 1 << IDX_W;

   mem_state_e       state, next_state;
   logic [CNT_W-1:0] cnt, cnt_next;
   mem_req_t         req_q, req_in, req_cur;
   logic             load;
   logic             enter_resp;
   logic [IDX_W-1:0] idx_cur;

   logic [BLK_W-1:0] mem_array [DEPTH];

   // Aliasing: upper address bits play no part in the access
   logic unused_addr_bits;
   assign unused_addr_bits = ^{mem_addr[MADDR_W-1:IDX_W], req_q.addr[MADDR_W-1:IDX_W]};

   // Next-state and counter logic; with LATENCY==1 the request goes straight to RESP
   always_comb begin
      next_state = state;
      cnt_next   = cnt;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (mem_read || mem_write) begin
               load       = 1'b1;
               cnt_next   = CNT_W'(LATENCY - 1);
               next_state = (LATENCY == 1) ? RESP : BUSY;
            end
         end
         BUSY: begin
            cnt_next = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               next_state = RESP;
            end
         end
         RESP:    next_state = GAP;
         GAP:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // The access on RESP entry may coincide with the latch edge when LATENCY==1
   always_comb begin
      req_in.is_write = mem_write;
      req_in.addr     = mem_addr;
      req_in.wdata    = mem_wdata;
      req_cur         = load ? req_in : req_q;
      enter_resp      = (next_state == RESP) && (state != RESP);
      idx_cur         = req_cur.addr[IDX_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         req_q     <= '0;
         mem_ready <= 1'b0;
         mem_rdata <= '0;
      end else begin
         state     <= next_state;
         cnt       <= cnt_next;
         mem_ready <= (state == RESP);
         if (load) begin
            req_q <= req_in;
         end
         if (enter_resp && !req_cur.is_write) begin
            mem_rdata <= mem_array[idx_cur];
         end
      end
   end

   // Storage is never cleared; reset only suppresses a pending commit
   always_ff @(posedge clk) begin
      if (!rst && enter_resp && req_cur.is_write) begin
         mem_array[idx_cur] <= req_cur.wdata;
      end
   end

`ifdef MEM_PROTO_CHECK_EN
   mem_proto_checker u_checker (
      .clk       (clk),
      .rst       (rst),
      .state     (state),
      .lat_req   (req_q),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .proto_err (proto_err)
   );
`else
   assign proto_err = 1'b0;
`endif

endmodule
